mult_div_unit: RTL

Parametrised multi-cycle multiply/divide unit for the multicycle CPU datapath, producing the HI/LO pair consumed by the mfhi/mflo paths. It accepts one operation per start pulse, iterates one bit per clock and holds its results until the next operation completes. The block generalises the fixed 32-bit ALU path in three ways: operand width is parametrised, signed and unsigned modes are both supported, and the unit adds a start/done handshake with divide-by-zero reporting.

---
 rtl/mdu_pkg.sv | 15 +
 rtl/mult_div_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned multiply and divide producing the HI/LO pair.
// One operand bit per clock; sign correction is applied in a final FIX cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic                   is_div_q, is_div_d;
    logic                   neg_res_q, neg_res_d;
    logic                   neg_rem_q, neg_rem_d;
    logic                   dz_pend_q, dz_pend_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   div_zero_q, div_zero_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;

    logic                   signed_op;
    logic [WIDTH-1:0]       abs_a;
    logic [WIDTH-1:0]       abs_b;
    logic [WIDTH:0]         sum_w;
    logic [WIDTH:0]         shifted;
    logic [WIDTH:0]         diff;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix;
    logic [WIDTH-1:0]       rem_fix;

    assign signed_op = ~op[0];
    assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

    // Multiply accumulates into the upper half and shifts right; the carry
    // out of the add becomes the new top bit.
    assign sum_w     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};

    // Restoring divide: the dividend shifts out of acc_q's low half while
    // quotient bits shift in behind it.
    assign shifted   = {rem_q, acc_q[WIDTH-1]};
    assign diff      = shifted - {1'b0, opnd_q};

    assign prod_fix  = neg_res_q ? -acc_q : acc_q;
    assign quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        rem_d      = rem_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_pend_d  = dz_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d   = op[1];
                    neg_res_d  = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d  = signed_op & a[WIDTH-1];
                    opnd_d     = abs_b;
                    acc_d      = {{WIDTH{1'b0}}, abs_a};
                    rem_d      = '0;
                    cnt_d      = CNT_W'(WIDTH);
                    busy_d     = 1'b1;
                    div_zero_d = 1'b0;
                    // A zero divisor goes straight to FIX so done follows next edge.
                    if (op[1] && (b == '0)) begin
                        dz_pend_d = 1'b1;
                        state_d   = S_FIX;
                    end else begin
                        dz_pend_d = 1'b0;
                        state_d   = S_RUN;
                    end
                end
            end

            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div_q) begin
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (acc_q[0]) begin
                        acc_d = {sum_w, acc_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                    end
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dz_pend_q) begin
                    div_zero_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            rem_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_pend_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            rem_q      <= rem_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_pend_q  <= dz_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
